// File: rtl/mem_pkg.sv
// Shared constants and types for the memory-access stage and its lane-alignment helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        reg_write;
    logic        err;
  } wb_rec_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store lane replication and byte enables,
// load extraction with sign/zero extension, and access legality checking.
module lsu_align
  import mem_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        fault_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic       illegal;
  logic       misaligned;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  // The low two funct3 bits give the access size for both loads and stores.
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = st_data_i;
    misaligned = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{st_data_i[15:0]}};
        misaligned = addr_lo_i[0];
      end
      default: begin
        be_o       = 4'b1111;
        wdata_o    = st_data_i;
        misaligned = (addr_lo_i != 2'b00);
      end
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    if (is_load_i) begin
      illegal = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end else if (is_store_i) begin
      illegal = !(funct3_i inside {F3_B, F3_H, F3_W});
    end
  end

  // Unknown sizes always fault; alignment faults only when checking is enabled.
  assign fault_o = (is_load_i | is_store_i) & (illegal | (CHECK_ALIGN & misaligned));

  always_comb begin
    ld_byte = rdata_i[7:0];
    case (ld_addr_lo_i)
      2'b00:   ld_byte = rdata_i[7:0];
      2'b01:   ld_byte = rdata_i[15:8];
      2'b10:   ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0, ld_half};
      F3_W:    ld_data_o = rdata_i;
      default: ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results, runs the data-memory req/ack
// handshake for loads and stores, and emits one registered writeback record per op.
module mem_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_alu_out,
  input  logic [31:0]       ex_rs2_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_reg_write,
  output logic              misalign_err
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [4:0]        rd_q, rd_d;
  logic              regw_q, regw_d;
  logic              load_q, load_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lo_q, lo_d;
  logic              kill_q, kill_d;
  logic              wb_valid_q, wb_valid_d;
  wb_rec_t           wb_q, wb_d;

  logic        is_mem;
  logic        accept;
  logic        fault;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign is_mem   = ex_mem_read | ex_mem_write;
  assign ex_ready = (state_q == IDLE) & ~flush;
  assign accept   = ex_valid & ex_ready;

  lsu_align #(
    .CHECK_ALIGN(CHECK_ALIGN)
  ) u_align (
    .is_load_i   (ex_mem_read),
    .is_store_i  (ex_mem_write),
    .funct3_i    (ex_funct3),
    .addr_lo_i   (ex_alu_out[1:0]),
    .st_data_i   (ex_rs2_data),
    .be_o        (st_be),
    .wdata_o     (st_wdata),
    .fault_o     (fault),
    .ld_funct3_i (f3_q),
    .ld_addr_lo_i(lo_q),
    .rdata_i     (dmem_rdata),
    .ld_data_o   (ld_data)
  );

  // wb fields hold by default; only the error flag is forced back to a pulse.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    regw_d     = regw_q;
    load_d     = load_q;
    f3_d       = f3_q;
    lo_d       = lo_q;
    kill_d     = kill_q;
    wb_valid_d = 1'b0;
    wb_d       = wb_q;
    wb_d.err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_d = '{rd: ex_rd, data: ex_alu_out, reg_write: ex_reg_write, err: 1'b0};
          end else if (fault) begin
            wb_valid_d = 1'b1;
            wb_d = '{rd: ex_rd, data: ex_alu_out, reg_write: 1'b0, err: 1'b1};
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = ex_mem_write;
            addr_d  = {ex_alu_out[ADDR_W-1:2], 2'b00};
            wdata_d = st_wdata;
            be_d    = st_be;
            rd_d    = ex_rd;
            regw_d  = ex_reg_write;
            load_d  = ex_mem_read;
            f3_d    = ex_funct3;
            lo_d    = ex_alu_out[1:0];
            kill_d  = 1'b0;
          end
        end
      end
      BUSY: begin
        // A flushed access still has to finish its handshake; it just never retires.
        kill_d = kill_q | flush;
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          kill_d  = 1'b0;
          if (!(kill_q | flush)) begin
            wb_valid_d = 1'b1;
            wb_d = '{rd: rd_q, data: load_q ? ld_data : 32'h0,
                     reg_write: load_q & regw_q, err: 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
      rd_q       <= 5'h0;
      regw_q     <= 1'b0;
      load_q     <= 1'b0;
      f3_q       <= 3'h0;
      lo_q       <= 2'h0;
      kill_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      regw_q     <= regw_d;
      load_q     <= load_d;
      f3_q       <= f3_d;
      lo_q       <= lo_d;
      kill_q     <= kill_d;
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_q.rd;
  assign wb_data      = wb_q.data;
  assign wb_reg_write = wb_q.reg_write;
  assign misalign_err = wb_q.err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        flush;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic        misalign_err;

  always #5 clk = ~clk;

  mem_stage #(
    .ADDR_W(32),
    .CHECK_ALIGN(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .misalign_err(misalign_err)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        regw;
    logic        mrd;
    logic        mwr;
    logic [2:0]  f3;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
  } stim_t;

  // Model view: one optional outstanding access plus the last writeback record.
  typedef struct packed {
    logic        busy;
    logic        we;
    logic        load;
    logic        regw;
    logic        kill;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wbv;
    logic        err;
    logic        wb_regw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
  } mdl_t;

  mdl_t cur, nxt;
  logic e_ready;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int accBytes(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic bit faults(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else    legal = (f3 <= 3'd2);
    if (!legal) return 1'b1;
    return (int'(a[1:0]) % accBytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] laneMask(input logic [2:0] f3, input logic [31:0] a);
    int n = accBytes(f3);
    return 4'(((1 << n) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] laneData(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    int n = accBytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] loadValue(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    logic [31:0] mask;
    int n = accBytes(f3);
    v = rdata >> (8 * int'(a[1:0]));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic mdlReset();
    cur = '0;
    nxt = '0;
    e_ready = 1'b1;
  endtask

  // Predicts the state seen after the coming clock edge from the inputs now driven.
  task automatic mdlPlan();
    nxt = cur;
    nxt.wbv = 1'b0;
    nxt.err = 1'b0;
    e_ready = !cur.busy && !flush;
    if (!cur.busy) begin
      if (ex_valid && !flush) begin
        if (!ex_mem_read && !ex_mem_write) begin
          nxt.wbv = 1'b1; nxt.wb_rd = ex_rd; nxt.wb_data = ex_alu_out; nxt.wb_regw = ex_reg_write;
        end else if (faults(ex_mem_read, ex_funct3, ex_alu_out)) begin
          nxt.wbv = 1'b1; nxt.err = 1'b1; nxt.wb_rd = ex_rd;
          nxt.wb_data = ex_alu_out; nxt.wb_regw = 1'b0;
        end else begin
          nxt.busy = 1'b1; nxt.we = ex_mem_write; nxt.load = ex_mem_read;
          nxt.addr = ex_alu_out; nxt.f3 = ex_funct3; nxt.rd = ex_rd;
          nxt.regw = ex_reg_write; nxt.kill = 1'b0;
          nxt.wdata = laneData(ex_funct3, ex_rs2_data);
          nxt.be = laneMask(ex_funct3, ex_alu_out);
        end
      end
    end else if (dmem_ack) begin
      nxt.busy = 1'b0;
      nxt.kill = 1'b0;
      if (!cur.kill && !flush) begin
        nxt.wbv = 1'b1;
        nxt.wb_rd = cur.rd;
        nxt.wb_data = cur.load ? loadValue(cur.f3, cur.addr, dmem_rdata) : 32'h0;
        nxt.wb_regw = cur.load && cur.regw;
      end
    end else if (flush) begin
      nxt.kill = 1'b1;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    cur = nxt;
    ex_valid = s.valid; ex_alu_out = s.alu; ex_rs2_data = s.rs2; ex_rd = s.rd;
    ex_reg_write = s.regw; ex_mem_read = s.mrd; ex_mem_write = s.mwr; ex_funct3 = s.f3;
    flush = s.flush; dmem_ack = s.ack; dmem_rdata = s.rdata;
    mdlPlan();
    @(negedge clk);
  endtask

  function automatic stim_t idleS();
    return '0;
  endfunction

  function automatic stim_t aluS(input logic [31:0] alu, input logic [4:0] rd);
    stim_t s = '0;
    s.valid = 1'b1; s.alu = alu; s.rd = rd; s.regw = 1'b1;
    return s;
  endfunction

  function automatic stim_t memS(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] rs2, input logic [4:0] rd);
    stim_t s = '0;
    s.valid = 1'b1; s.alu = a; s.rs2 = rs2; s.rd = rd; s.regw = ld;
    s.mrd = ld; s.mwr = !ld; s.f3 = f3;
    return s;
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      checkOutput("ex_ready", 32'(ex_ready), 32'(e_ready));
      checkOutput("wb_valid", 32'(wb_valid), 32'(cur.wbv));
      checkOutput("misalign_err", 32'(misalign_err), 32'(cur.err));
      checkOutput("wb_rd", 32'(wb_rd), 32'(cur.wb_rd));
      checkOutput("wb_data", wb_data, cur.wb_data);
      checkOutput("wb_reg_write", 32'(wb_reg_write), 32'(cur.wb_regw));
      checkOutput("dmem_req", 32'(dmem_req), 32'(cur.busy));
      if (cur.busy) begin
        checkOutput("dmem_addr", dmem_addr, {cur.addr[31:2], 2'b00});
        checkOutput("dmem_we", 32'(dmem_we), 32'(cur.we));
        if (cur.we) begin
          checkOutput("dmem_be", 32'(dmem_be), 32'(cur.be));
          checkOutput("dmem_wdata", dmem_wdata, cur.wdata);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cnt;
    int    kind;

    rst = 1'b1;
    ex_valid = 1'b0; ex_alu_out = '0; ex_rs2_data = '0; ex_rd = '0; ex_reg_write = 1'b0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0; flush = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset ex_ready", 32'(ex_ready), 32'd1);
    checkOutput("reset dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("reset wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset misalign_err", 32'(misalign_err), 32'd0);
    checkOutput("reset wb_data", wb_data, 32'd0);
    checkOutput("reset dmem_be", 32'(dmem_be), 32'd0);
    rst = 1'b0;
    mdlReset();
    #1 chk_en = 1'b1;

    // Non-memory op, then three back-to-back ops.
    applyStimulus(aluS(32'h0000_1234, 5'd5));
    applyStimulus(aluS(32'h0000_0011, 5'd1));
    checkOutput("alu wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("alu wb_data", wb_data, 32'h0000_1234);
    checkOutput("alu wb_rd", 32'(wb_rd), 32'd5);
    applyStimulus(aluS(32'h0000_0022, 5'd2));
    checkOutput("b2b wb 1", wb_data, 32'h0000_0011);
    applyStimulus(idleS());
    checkOutput("b2b wb 2", wb_data, 32'h0000_0022);
    checkOutput("b2b valid 2", 32'(wb_valid), 32'd1);
    applyStimulus(idleS());
    checkOutput("b2b valid end", 32'(wb_valid), 32'd0);

    // LB / LBU at a lane-3 address.
    applyStimulus(memS(1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd7));
    s = idleS(); s.ack = 1'b1; s.rdata = 32'h80FF_0000;
    applyStimulus(s);
    checkOutput("lb dmem_addr", dmem_addr, 32'h0000_0100);
    checkOutput("lb dmem_req", 32'(dmem_req), 32'd1);
    checkOutput("lb ex_ready busy", 32'(ex_ready), 32'd0);
    applyStimulus(idleS());
    checkOutput("lb wb_data", wb_data, 32'hFFFF_FF80);
    checkOutput("lb ex_ready after ack", 32'(ex_ready), 32'd1);
    applyStimulus(memS(1'b1, 3'b100, 32'h0000_0103, 32'h0, 5'd7));
    applyStimulus(s);
    applyStimulus(idleS());
    checkOutput("lbu wb_data", wb_data, 32'h0000_0080);

    // SH with ack delayed three cycles.
    applyStimulus(memS(1'b0, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd0));
    for (int i = 0; i < 4; i++) begin
      s = idleS(); s.ack = (i == 3);
      applyStimulus(s);
      checkOutput("sh dmem_be", 32'(dmem_be), 32'h0000_000C);
      checkOutput("sh dmem_wdata", dmem_wdata, 32'hBEEF_BEEF);
      checkOutput("sh ex_ready", 32'(ex_ready), 32'd0);
    end
    applyStimulus(idleS());
    checkOutput("sh wb_valid", 32'(wb_valid), 32'd1);
    checkOutput("sh wb_reg_write", 32'(wb_reg_write), 32'd0);

    // Misaligned LW.
    applyStimulus(memS(1'b1, 3'b010, 32'h0000_0301, 32'h0, 5'd4));
    applyStimulus(idleS());
    checkOutput("lw mis dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("lw mis err", 32'(misalign_err), 32'd1);
    checkOutput("lw mis wb_data", wb_data, 32'h0000_0301);
    checkOutput("lw mis wb_reg_write", 32'(wb_reg_write), 32'd0);

    // Flush in the second BUSY cycle of a LW.
    applyStimulus(memS(1'b1, 3'b010, 32'h0000_0400, 32'h0, 5'd9));
    applyStimulus(idleS());
    s = idleS(); s.flush = 1'b1;
    applyStimulus(s);
    checkOutput("flush req held", 32'(dmem_req), 32'd1);
    s = idleS(); s.ack = 1'b1; s.rdata = 32'h1234_5678;
    applyStimulus(s);
    checkOutput("flush req until ack", 32'(dmem_req), 32'd1);
    applyStimulus(aluS(32'h0000_0055, 5'd3));
    checkOutput("flush no wb", 32'(wb_valid), 32'd0);
    checkOutput("flush accept next", 32'(ex_ready), 32'd1);
    applyStimulus(idleS());
    checkOutput("after flush wb_data", wb_data, 32'h0000_0055);

    // Randomized traffic with a responder that always acks within a few cycles.
    wait_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      s = idleS();
      s.valid = ($urandom_range(3) != 0);
      kind = int'($urandom_range(2));
      s.mrd = (kind == 1);
      s.mwr = (kind == 2);
      s.f3 = 3'($urandom_range(7));
      s.alu = $urandom();
      if ($urandom_range(1) == 1) s.alu = {20'h0, s.alu[11:0]};
      s.rs2 = $urandom();
      s.rd = 5'($urandom());
      s.regw = 1'($urandom_range(1));
      s.flush = ($urandom_range(7) == 0);
      s.rdata = $urandom();
      if (nxt.busy) begin
        wait_cnt++;
        s.ack = (wait_cnt >= 4) || ($urandom_range(2) == 0);
      end else begin
        wait_cnt = 0;
      end
      applyStimulus(s);
    end

    // Reset asserted in the middle of an access.
    applyStimulus(idleS());
    applyStimulus(idleS());
    applyStimulus(memS(1'b1, 3'b010, 32'h0000_0500, 32'h0, 5'd6));
    applyStimulus(idleS());
    checkOutput("pre-reset dmem_req", 32'(dmem_req), 32'd1);
    chk_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("mid-reset dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("mid-reset ex_ready", 32'(ex_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdlReset();
    #1 chk_en = 1'b1;
    applyStimulus(idleS());
    checkOutput("post-reset wb_valid", 32'(wb_valid), 32'd0);
    applyStimulus(aluS(32'h0000_0AB0, 5'd10));
    applyStimulus(idleS());
    checkOutput("post-reset alu wb_data", wb_data, 32'h0000_0AB0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU.
- Consumes the ALU result, which is the effective address for loads and stores or the writeback value for all other ops.
- Runs a req/ack handshake with the data memory for loads and stores: byte-lane alignment, byte enables, load sign/zero extension.
- Presents one registered writeback record per instruction and back-pressures execute while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width; the low 2 bits select the byte lane.
- CHECK_ALIGN, 1, when 1 misaligned halfword/word accesses raise misalign_err; when 0 the low address bits are ignored for H/W accesses.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage can accept; transfer occurs when ex_valid & ex_ready.
- ex_alu_out  in  32  ALU result or effective address.
- ex_rs2_data  in  32  store data.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes rd.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store (never asserted together with ex_mem_read).
- ex_funct3  in  3  access size/sign.
- flush  in  1  kill the current/in-flight instruction.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write request.
- dmem_addr  out  ADDR_W  word-aligned address.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- dmem_ack  in  1  access complete.
- wb_valid  out  1  writeback record valid (one-cycle pulse).
- wb_rd  out  5  destination.
- wb_data  out  32  writeback value.
- wb_reg_write  out  1  register-file write enable.
- misalign_err  out  1  exception pulse, coincident with wb_valid.

Behaviour:
- Reset: every output is 0 except ex_ready=1; FSM returns to IDLE. Reset mid-access drops the access and deasserts dmem_req immediately.
- FSM states: IDLE, BUSY.
- ex_ready = (state==IDLE) & ~flush.
- Acceptance in IDLE, non-memory op: at the next edge wb_valid=1, wb_data=ex_alu_out, wb_rd, wb_reg_write. Latency 1; stays in IDLE; back-to-back acceptance every cycle.
- Acceptance in IDLE, memory op, legal and aligned: at the next edge enter BUSY and latch all request fields.
  - dmem_req=1 throughout BUSY; dmem_addr, dmem_we, dmem_wdata and dmem_be are held stable until ack.
- Ack: dmem_ack is sampled on the edge while dmem_req=1 and may arrive in the first BUSY cycle.
  - On the ack edge: return to IDLE and assert wb_valid for one cycle.
  - Load: wb_data = extracted read data.
  - Store: wb_reg_write=0, wb_data=0.
  - ex_ready is therefore high again in the same cycle wb_valid pulses.
- Address and lane rules:
  - dmem_addr = {addr[ADDR_W-1:2],2'b00}.
  - SB (000): be = 1<<addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH (001): be = addr[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - SW (010): be = 1111; wdata = rs2.
- Load extraction:
  - LB (000) / LBU (100): select byte addr[1:0]; sign-extend for LB, zero-extend for LBU.
  - LH (001) / LHU (101): select half addr[1]; sign-extend for LH, zero-extend for LHU.
  - LW (010): full word.
- Misalignment (CHECK_ALIGN=1):
  - Faulting cases: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: load funct3 011/110/111, or store funct3 other than 000/001/010.
  - Faulting access: no memory request; next edge wb_valid=1, misalign_err=1, wb_reg_write=0, wb_data=faulting address; stays in IDLE.
- Flush:
  - In IDLE: no instruction is accepted that cycle.
  - In BUSY: the request is NOT withdrawn (the handshake must complete). A sticky kill bit is set, and on ack wb_valid stays 0 and no error is raised.
  - Flush in the ack cycle: also suppresses wb_valid.
- Outputs are registered; wb_* fields hold their last value while wb_valid=0.

Decomposition:
- Package mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum IDLE/BUSY;
  - a wb record struct (rd, data, reg_write, err).
- One combinational sub-module, lsu_align, contains:
  - store lane/be generation;
  - load extraction;
  - misalign/illegal detection.
- FSM and registers stay in mem_stage.

Test Plan:
- Reset asserted mid-BUSY -> dmem_req=0 and ex_ready=1 immediately; wb_valid=0 after release.
- Non-memory op, alu_out=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5; three back-to-back ops give wb_valid on three consecutive cycles.
- LB addr=0x103 with rdata=0x80FF_0000 -> dmem_addr=0x100; wb_data=0xFFFF_FF80. LBU at the same address -> wb_data=0x0000_0080.
- SH addr=0x202, rs2=0xAAAA_BEEF, ack delayed 3 cycles:
  - dmem_be=1100, dmem_wdata=0xBEEF_BEEF, held stable for 4 cycles;
  - ex_ready=0 until ack;
  - wb_valid with wb_reg_write=0.
- LW addr=0x301 -> no dmem_req; next cycle misalign_err=1, wb_data=0x301, wb_reg_write=0.
- Flush asserted in the second BUSY cycle of a LW -> dmem_req held until ack; no wb_valid; the next instruction is accepted in the cycle after ack.
